fetch_queue: RTL and testbench

- Instruction prefetch stage between unified byte memory and the instruction decoder/core.
- Owns the fetch PC and issues one 32-bit read at a time to a variable-latency memory port using a req/ack handshake.
- Buffers returned instructions, with their PCs, in a FIFO and delivers them to decode with valid/ready.
- A branch redirect flushes all buffered instructions and discards any in-flight response.

---
 rtl/fetch_queue.sv | 163 ++++++++++++++++
 tb/tb_fetch_queue.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch with req/ack memory port and PC-tagged FIFO.
// Optional halt detection is built when HALT_DETECT_EN is defined.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_stopped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t      state, state_nx;
    logic [AW:0] count, count_nx;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0] instr_q [DEPTH];
    logic [63:0] pc_q    [DEPTH];
    logic [63:0] fetch_pc, fetch_pc_nx, mem_addr_nx, redir_pc;
    logic        mem_req_nx, push, pop, slot_ok;
    logic        halt_hit, stopped, stopped_nx;

    assign redir_pc  = redirect_pc & ~64'd3;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = (state == WAIT) && mem_ack && !redirect;
    assign slot_ok   = (count_nx < FULL);
    assign out_instr = instr_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];
    assign fetch_stopped = stopped;

`ifdef HALT_DETECT_EN
    assign halt_hit = push && (mem_rdata[31:27] == 5'h0f);
`else
    assign halt_hit = 1'b0;
`endif

    // Occupancy after this cycle's redirect/push/pop.
    always_comb begin
        count_nx = count;
        if (redirect)
            count_nx = '0;
        else if (push && !pop)
            count_nx = count + ONE;
        else if (pop && !push)
            count_nx = count - ONE;
    end

    // Fetch FSM: next state, request and fetch PC.
    always_comb begin
        state_nx    = state;
        mem_req_nx  = mem_req;
        mem_addr_nx = mem_addr;
        fetch_pc_nx = fetch_pc;
        stopped_nx  = stopped;
        unique case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_nx = redir_pc;
                    stopped_nx  = 1'b0;
                    state_nx    = WAIT;
                    mem_req_nx  = 1'b1;
                    mem_addr_nx = redir_pc;
                end else if (slot_ok && !stopped) begin
                    state_nx    = WAIT;
                    mem_req_nx  = 1'b1;
                    mem_addr_nx = fetch_pc;
                end
            end
            WAIT: begin
                if (redirect) begin
                    fetch_pc_nx = redir_pc;
                    stopped_nx  = 1'b0;
                    if (mem_ack)
                        mem_addr_nx = redir_pc;
                    else
                        state_nx = DRAIN;
                end else if (mem_ack) begin
                    fetch_pc_nx = mem_addr + 64'd4;
                    if (halt_hit) begin
                        stopped_nx = 1'b1;
                        mem_req_nx = 1'b0;
                        state_nx   = IDLE;
                    end else if (slot_ok) begin
                        mem_addr_nx = mem_addr + 64'd4;
                    end else begin
                        mem_req_nx = 1'b0;
                        state_nx   = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_nx = redir_pc;
                    stopped_nx  = 1'b0;
                end
                if (mem_ack) begin
                    state_nx    = WAIT;
                    mem_addr_nx = redirect ? redir_pc : fetch_pc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM and request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            fetch_pc <= RESET_PC;
            stopped  <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_req  <= mem_req_nx;
            mem_addr <= mem_addr_nx;
            fetch_pc <= fetch_pc_nx;
            stopped  <= stopped_nx;
        end
    end

    // FIFO storage and pointers; redirect empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= mem_rdata;
                pc_q[wr_ptr]    <= mem_addr;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nx;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against
// a stream-level reference model and a variable-latency memory model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_stopped;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .fetch_stopped(fetch_stopped)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // memory model controls
    int lat_cfg = 0;
    bit rand_lat = 0;
    bit halt_on = 0;
    int cur_lat = 0;
    int wcnt = 0;
    bit req_d = 0;

    // reference model state
    int          ent = 0;
    int          acc_cnt = 0;
    logic [63:0] exp_out = RPC;
    logic [63:0] exp_fetch = RPC;
    bit          stale = 0;
    bit          m_stop = 0;
    bit          prev_pend = 0;
    logic [63:0] prev_addr = '0;
    int          n;

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (halt_on && a == 64'h2008) return 32'h7800_0000;
        return a[31:0];
    endfunction

    // memory: acks after cur_lat idle cycles of a request
    always @(posedge clk) begin
        #1;
        if (reset || !mem_req) begin
            mem_ack = 1'b0;
            wcnt    = 0;
            req_d   = 1'b0;
        end else begin
            if (!req_d || mem_ack) begin
                wcnt    = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
            end
            req_d = 1'b1;
            if (wcnt >= cur_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = word_at(mem_addr);
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle against the model, advance model, clock once.
    task automatic step();
        if (reset) begin
            ent = 0;
            stale = 0;
            m_stop = 0;
            exp_out = RPC;
            exp_fetch = RPC;
            prev_pend = 0;
        end else begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, ent != 0});
            chk("fetch_stopped", {63'd0, fetch_stopped}, {63'd0, m_stop});
            if (prev_pend) begin
                chk("req_held", {63'd0, mem_req}, 64'd1);
                chk("addr_held", mem_addr, prev_addr);
            end
            if (out_valid && out_ready && ent > 0) begin
                chk("out_pc", out_pc, exp_out);
                chk("out_instr", {32'd0, out_instr}, {32'd0, word_at(exp_out)});
                exp_out = exp_out + 64'd4;
                ent--;
            end
            if (mem_req && mem_ack) begin
                if (stale) begin
                    stale = 0;
                end else if (!redirect) begin
                    chk("ack_addr", mem_addr, exp_fetch);
                    exp_fetch = exp_fetch + 64'd4;
                    ent++;
                    acc_cnt++;
`ifdef HALT_DETECT_EN
                    if (mem_rdata[31:27] == 5'h0f) m_stop = 1;
`endif
                end
            end
            if (redirect) begin
                ent = 0;
                exp_out = redirect_pc & ~64'd3;
                exp_fetch = redirect_pc & ~64'd3;
                stale = mem_req && !mem_ack;
                m_stop = 0;
            end
            prev_pend = mem_req && !mem_ack;
            prev_addr = mem_addr;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        step();
        step();
        reset = 1'b0;
        acc_cnt = 0;
    endtask

    initial begin
        // T1: streaming, single-cycle ack, consumer always ready
        lat_cfg = 0;
        out_ready = 1'b1;
        reset = 1'b1;
        step();
        step();
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_stop", {63'd0, fetch_stopped}, 64'd0);
        reset = 1'b0;
        step();
        chk("t1_first_req", {63'd0, mem_req}, 64'd1);
        chk("t1_first_addr", mem_addr, 64'h2000);
        step();
        chk("t1_ack_to_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_first_pc", out_pc, 64'h2000);
        repeat (10) begin
            chk("t1_no_bubble", {63'd0, mem_req}, 64'd1);
            step();
        end

        // T2: consumer stalled, FIFO fills to DEPTH
        out_ready = 1'b0;
        do_reset();
        repeat (10) step();
        chk("t2_acks", 64'(acc_cnt), 64'd4);
        chk("t2_req_off", {63'd0, mem_req}, 64'd0);
        chk("t2_head", out_pc, 64'h2000);
        out_ready = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin step(); n++; end
        chk("t2_resume_req", {63'd0, mem_req}, 64'd1);
        chk("t2_resume_addr", mem_addr, 64'h2010);
        repeat (6) step();

        // T3: redirect while a slow request is outstanding
        lat_cfg = 3;
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 64'h2008) && n < 40) begin step(); n++; end
        chk("t3_found", {63'd0, mem_req && mem_addr == 64'h2008}, 64'd1);
        step();
        redirect = 1'b1;
        redirect_pc = 64'h3002;
        chk("t3_no_ack_yet", {63'd0, mem_ack}, 64'd0);
        step();
        redirect = 1'b0;
        chk("t3_empty", {63'd0, out_valid}, 64'd0);
        n = 0;
        while (mem_addr == 64'h2008 && n < 20) begin step(); n++; end
        chk("t3_next_addr", mem_addr, 64'h3000);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("t3_first_pc", out_pc, 64'h3000);
        repeat (4) step();

        // T4: redirect with ack, then redirects during DRAIN
        lat_cfg = 1;
        do_reset();
        n = 0;
        while (!(mem_ack && mem_addr == 64'h2004) && n < 40) begin step(); n++; end
        chk("t4_found", {63'd0, mem_ack && mem_addr == 64'h2004}, 64'd1);
        redirect = 1'b1;
        redirect_pc = 64'h5000;
        lat_cfg = 3;
        step();
        chk("t4_req", {63'd0, mem_req}, 64'd1);
        chk("t4_addr", mem_addr, 64'h5000);
        chk("t4_flushed", {63'd0, out_valid}, 64'd0);
        redirect_pc = 64'h5800;
        step();
        redirect_pc = 64'h6000;
        chk("t4_drain_noack", {63'd0, mem_ack}, 64'd0);
        step();
        redirect = 1'b0;
        n = 0;
        while (mem_addr == 64'h5000 && n < 20) begin step(); n++; end
        chk("t4_next_addr", mem_addr, 64'h6000);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("t4_first_pc", out_pc, 64'h6000);
        repeat (4) step();

        // T5: reset with a request outstanding and two entries held
        lat_cfg = 0;
        out_ready = 1'b0;
        do_reset();
        n = 0;
        while (ent != 2 && n < 20) begin step(); n++; end
        chk("t5_pre_req", {63'd0, mem_req}, 64'd1);
        chk("t5_pre_valid", {63'd0, out_valid}, 64'd1);
        reset = 1'b1;
        step();
        chk("t5_req_off", {63'd0, mem_req}, 64'd0);
        chk("t5_valid_off", {63'd0, out_valid}, 64'd0);
        reset = 1'b0;
        step();
        chk("t5_restart_req", {63'd0, mem_req}, 64'd1);
        chk("t5_restart_addr", mem_addr, 64'h2000);

        // T6: fetch address wraps modulo 2^64
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF9;
        step();
        redirect = 1'b0;
        n = 0;
        while (!(out_valid && out_pc[63:32] == 32'd0) && n < 20) begin step(); n++; end
        chk("t6_wrap_pc", out_pc, 64'h0);
        repeat (4) step();

        // T7: halt opcode at 0x2008
        halt_on = 1'b1;
        lat_cfg = 0;
`ifdef HALT_DETECT_EN
        out_ready = 1'b0;
        do_reset();
        repeat (8) step();
        chk("t7_stopped", {63'd0, fetch_stopped}, 64'd1);
        chk("t7_req_off", {63'd0, mem_req}, 64'd0);
        chk("t7_acks", 64'(acc_cnt), 64'd3);
        out_ready = 1'b1;
        repeat (4) step();
        chk("t7_drained", {63'd0, out_valid}, 64'd0);
        chk("t7_still_off", {63'd0, mem_req}, 64'd0);
        halt_on = 1'b0;
        redirect = 1'b1;
        redirect_pc = 64'h2000;
        step();
        redirect = 1'b0;
        chk("t7_resume_stop", {63'd0, fetch_stopped}, 64'd0);
        chk("t7_resume_req", {63'd0, mem_req}, 64'd1);
        chk("t7_resume_addr", mem_addr, 64'h2000);
        repeat (4) step();
`else
        out_ready = 1'b1;
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 64'h2010) && n < 20) begin step(); n++; end
        chk("t7_past_halt", {63'd0, mem_req && mem_addr == 64'h2010}, 64'd1);
        chk("t7_never_stop", {63'd0, fetch_stopped}, 64'd0);
        repeat (4) step();
        halt_on = 1'b0;
`endif

        // Random traffic: latency, backpressure and redirects
        rand_lat = 1;
        do_reset();
        repeat (1500) begin
            out_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = {32'd0, 32'($urandom_range(0, 32'h0FFF_FFFF))};
            step();
        end
        redirect = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
